// File: rtl/puf_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_arbiter_pkg : shared FSM encoding, requester indices and defaults
// Rev 1.0
// ---------------------------------------------------------------------------
package puf_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FIRE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int REQ_CALIB       = 0;
  localparam int REQ_TEST        = 1;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/puf_arbiter_rr_sel2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_sel2 : two-requester round-robin selector, one-hot winner
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_sel2
  import puf_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] win
);

  // On contention the requester that was not served last wins.
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (last_grant == 1'(REQ_TEST)) ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/puf_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_arbiter : arbitrates two requesters onto one PUF core evaluation
// Rev 1.0
// ---------------------------------------------------------------------------
module puf_arbiter
  import puf_arbiter_pkg::*;
#(
  parameter int CHALLENGE_WIDTH = 32,
  parameter int RESPONSE_WIDTH  = 6,
  parameter int TIMEOUT         = DEFAULT_TIMEOUT
) (
  input  logic                       clk_1,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [CHALLENGE_WIDTH-1:0] chal0,
  input  logic [CHALLENGE_WIDTH-1:0] chal1,
  output logic [1:0]                 ack,
  output logic [1:0]                 grant,
  output logic [RESPONSE_WIDTH-1:0]  resp_raw,
  output logic                       resp_xor,
  output logic                       resp_err,
  output logic [CHALLENGE_WIDTH-1:0] puf_challenge,
  output logic                       puf_trigger,
  input  logic                       puf_done,
  input  logic [RESPONSE_WIDTH-1:0]  puf_raw,
  input  logic                       puf_xor,
  output logic [15:0]                eval_count,
  output logic [7:0]                 timeout_count
);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       done_q;
  logic       last_grant;
  logic [1:0] win;
  logic       done_rise;

  rr_sel2 u_rr_sel2 (
    .req        (req),
    .last_grant (last_grant),
    .win        (win)
  );

  // Only a fresh edge counts; a level left high from a prior op is ignored.
  assign done_rise = puf_done & ~done_q;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state         <= ST_IDLE;
      ack           <= 2'b00;
      grant         <= 2'b00;
      puf_trigger   <= 1'b0;
      resp_raw      <= '0;
      resp_xor      <= 1'b0;
      resp_err      <= 1'b0;
      puf_challenge <= '0;
      eval_count    <= 16'd0;
      timeout_count <= 8'd0;
      wait_cnt      <= 8'd0;
      done_q        <= 1'b0;
      last_grant    <= 1'(REQ_TEST);
    end else begin
      done_q <= puf_done;
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            grant         <= win;
            puf_challenge <= win[REQ_TEST] ? chal1 : chal0;
            state         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          puf_trigger <= 1'b1;
          state       <= ST_FIRE;
        end
        ST_FIRE: begin
          puf_trigger <= 1'b0;
          wait_cnt    <= 8'd0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is checked first so it wins over a coincident timeout.
          if (done_rise) begin
            resp_raw <= puf_raw;
            resp_xor <= puf_xor;
            resp_err <= 1'b0;
            if (eval_count != 16'hFFFF) eval_count <= eval_count + 16'd1;
            ack   <= grant;
            state <= ST_RESP;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            resp_err <= 1'b1;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            ack   <= grant;
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          ack        <= 2'b00;
          grant      <= 2'b00;
          last_grant <= grant[REQ_TEST];
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
